dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-requester arbiter and sequencer in front of the single-port 4 KiB data memory. It accepts word read/write requests from two requesters over valid/ready handshakes: port 0 is the CPU data port, port 1 is the loader/debug port. It grants the memory to one requester at a time in round-robin order, drives the memory's address, write-data and write-enable lines for exactly one cycle, and returns a registered completion with read data or an error flag.

## Interface
- DATA_W, 32, data and address width
- MEM_AW, 10, word-index bits of the memory (1024 words; byte addresses 0x000–0xFFF)

Ports:
- clock  in  1  single clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_write / req1_write  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  DATA_W  byte address
- req0_wdata / req1_wdata  in  DATA_W  write data
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_rvalid / req1_rvalid  out  1  one-cycle completion pulse
- req0_rdata / req1_rdata  out  DATA_W  read data, valid with rvalid
- req0_err / req1_err  out  1  error flag, valid with rvalid
- mem_addr  out  DATA_W  to memory address (memory uses bits [11:2])
- mem_wdata  out  DATA_W  to memory write data
- mem_we  out  1  to memory write enable
- mem_rdata  in  DATA_W  combinational read data from memory

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any valid is high, the winner's ready is asserted combinationally in the same cycle.
  - The handshake completes on valid && ready. Latch the winner id, write, addr, wdata and err, then go to ACCESS.
  - Only one ready is ever high at a time.
- Arbitration: round-robin on the last_grant register.
  - When both are valid, the port that was not granted last wins.
  - A single valid port wins regardless of last_grant.
  - last_grant updates on acceptance.
- err is set at acceptance when addr[1:0] != 0 or addr[31:12] != 0.
- ACCESS:
  - mem_addr and mem_wdata come from the latched payload.
  - mem_we = latched write && !latched err.
  - mem_rdata is captured into the response register; the captured value is forced to 0 on err or on a write.
  - Go to RESP.
- RESP:
  - Assert rvalid for the latched id only, with its rdata and err.
  - Return to IDLE.
- Requesters must hold valid and payload stable until ready. The block does not check this.
- ready is never asserted in ACCESS or RESP.
- Outside ACCESS: mem_we = 0, and mem_addr/mem_wdata hold their last latched values.

## Timing
- Accept at edge T (end of the IDLE cycle). ACCESS occupies cycle T..T+1, and the memory write commits at edge T+1. rvalid is high in cycle T+1..T+2.
- Latency from acceptance to rvalid is 2 cycles. Peak throughput is 1 request per 3 cycles.
- Back-to-back: the next ready can assert in the IDLE cycle after RESP.
- Reset values:
  - state = IDLE, last_grant = 1 (port 0 wins the first contention).
  - All ready, rvalid and err outputs 0; all rdata 0.
  - mem_addr = 0, mem_wdata = 0, mem_we = 0.
- Reset mid-operation: the asynchronous reset drops mem_we immediately.
  - A write in ACCESS with reset asserted before the edge does not commit.
  - A pending rvalid is lost. Requesters must re-issue.
- Simultaneous new valid on the other port during ACCESS/RESP: it waits, and wins at the next IDLE.

## Structure
- Package dm_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - MEM_BYTES = 4096
  - ERR_ADDR_MASK = 32'hFFFF_F003
  - port-id type (1 bit)
- Sub-module rr_arb2: combinational 2-way round-robin picker.
  - Inputs: valid[1:0], last_grant.
  - Outputs: grant one-hot, winner id.
- The top-level module holds the FSM, payload and response registers, and the memory-side drive.

## Test plan
- Reset, then port 0 writes 0xDEADBEEF to 0x010.
  - Required: req0_ready in cycle 0.
  - Required: mem_we = 1 only in cycle 1 with mem_addr = 0x010.
  - Required: req0_rvalid = 1 and err = 0 in cycle 2.
  - Then port 0 reads 0x010. Required: rdata = 0xDEADBEEF two cycles after acceptance.
- Both ports valid continuously, reads from 0x100 and 0x200.
  - Required: grants alternate 0,1,0,1, port 0 first after reset.
  - Required: each rvalid appears only on the owning port.
- Port 1 writes to 0x1002 (misaligned), then to 0x1000 (out of range).
  - Required for both: mem_we stays 0, req1_rvalid with err = 1 and rdata = 0.
  - Required: memory contents unchanged (checked by a later read).
- Write 0x12345678 to 0xFFC, then read 0xFFC.
  - Required: top word stores and returns correctly, err = 0.
- reset_n asserted during ACCESS of a write of 0x5555AAAA to 0x020.
  - Required: mem_we falls immediately and no rvalid is issued.
  - Required: after release, a read of 0x020 returns the pre-reset value.
  - Required: port 0 wins the next contention.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Two requesters share one single-port 4 KiB data memory.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef logic port_id_t;

  localparam int unsigned MEM_BYTES = 4096;

  localparam logic [31:0] ERR_ADDR_MASK =
    ~(32'(MEM_BYTES) - 32'd1) | 32'd3;

  typedef struct packed {
    port_id_t    id;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
  } req_t;

  function automatic logic addr_err(
    input logic [31:0] a
  );
    return |(a & ERR_ADDR_MASK);
  endfunction

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker.
// Contention goes to the port not granted last.
module rr_arb2
  import dm_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  port_id_t   last_grant,
  output logic [1:0] grant,
  output port_id_t   winner
);

  always_comb begin
    winner = 1'b0;
    unique case (1'b1)
      (valid == 2'b11): winner = ~last_grant;
      (valid == 2'b01): winner = 1'b0;
      (valid == 2'b10): winner = 1'b1;
      default:          winner = 1'b0;
    endcase
    grant = 2'b00;
    if (|valid)
      grant = winner ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter and sequencer for the data memory.
// One access per three cycles: accept, access, respond.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MEM_AW = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [DATA_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [DATA_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  port_id_t          last_grant;
  req_t              pl;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [1:0]        rv;

  logic [1:0]        valid;
  logic [1:0]        grant;
  port_id_t          winner;
  logic              idle;
  logic              accept;
  logic              sel_write;
  logic [DATA_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_err;

  assign valid = {req1_valid, req0_valid};

  rr_arb2 u_arb (
    .valid      (valid),
    .last_grant (last_grant),
    .grant      (grant),
    .winner     (winner)
  );

  assign idle       = (state == IDLE);
  assign req0_ready = idle & grant[0];
  assign req1_ready = idle & grant[1];
  assign accept     = idle & (|valid);

  assign sel_write = winner ? req1_write : req0_write;
  assign sel_addr  = winner ? req1_addr  : req0_addr;
  assign sel_wdata = winner ? req1_wdata : req0_wdata;
  assign sel_err   = addr_err(sel_addr)
                   | (|(sel_addr >> (MEM_AW + 2)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      pl         <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      rv         <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          rv <= 2'b00;
          if (accept) begin
            pl.id      <= winner;
            pl.write   <= sel_write;
            pl.addr    <= sel_addr;
            pl.wdata   <= sel_wdata;
            pl.err     <= sel_err;
            last_grant <= winner;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          rdata_q <= (pl.write | pl.err) ? '0 : mem_rdata;
          err_q   <= pl.err;
          rv      <= pl.id ? 2'b10 : 2'b01;
          state   <= RESP;
        end
        RESP: begin
          rv    <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // State is reset asynchronously, so a pending write never commits.
  assign mem_we    = (state == ACCESS) & pl.write & ~pl.err;
  assign mem_addr  = pl.addr;
  assign mem_wdata = pl.wdata;

  assign req0_rvalid = rv[0];
  assign req1_rvalid = rv[1];
  assign req0_rdata  = rv[0] ? rdata_q : '0;
  assign req1_rdata  = rv[1] ? rdata_q : '0;
  assign req0_err    = rv[0] & err_q;
  assign req1_err    = rv[1] & err_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 4 KiB memory.
// Per-cycle vector table plus a reset-during-access sequence.
module tb_dm_arbiter;

  logic        clock;
  logic        reset_n;
  logic        req0_valid, req0_write;
  logic [31:0] req0_addr, req0_wdata;
  logic        req0_ready, req0_rvalid, req0_err;
  logic [31:0] req0_rdata;
  logic        req1_valid, req1_write;
  logic [31:0] req1_addr, req1_wdata;
  logic        req1_ready, req1_rvalid, req1_err;
  logic [31:0] req1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [1024];

  int vectors;
  int miscompares;

  dm_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req0_valid  (req0_valid),
    .req0_write  (req0_write),
    .req0_addr   (req0_addr),
    .req0_wdata  (req0_wdata),
    .req0_ready  (req0_ready),
    .req0_rvalid (req0_rvalid),
    .req0_rdata  (req0_rdata),
    .req0_err    (req0_err),
    .req1_valid  (req1_valid),
    .req1_write  (req1_write),
    .req1_addr   (req1_addr),
    .req1_wdata  (req1_wdata),
    .req1_ready  (req1_ready),
    .req1_rvalid (req1_rvalid),
    .req1_rdata  (req1_rdata),
    .req1_err    (req1_err),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clock)
    if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

  typedef struct {
    string       nm;
    bit          rst;
    logic        v0, w0;
    logic [31:0] a0, d0;
    logic        v1, w1;
    logic [31:0] a1, d1;
    logic [6:0]  fl;
    logic [31:0] rd0, rd1, ma, md;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input string nm, input bit rst,
    input logic v0, input logic w0,
    input logic [31:0] a0, input logic [31:0] d0,
    input logic v1, input logic w1,
    input logic [31:0] a1, input logic [31:0] d1,
    input logic [6:0] fl,
    input logic [31:0] rd0, input logic [31:0] rd1,
    input logic [31:0] ma, input logic [31:0] md
  );
    vec_t t;
    t.nm = nm; t.rst = rst;
    t.v0 = v0; t.w0 = w0; t.a0 = a0; t.d0 = d0;
    t.v1 = v1; t.w1 = w1; t.a1 = a1; t.d1 = d1;
    t.fl = fl; t.rd0 = rd0; t.rd1 = rd1;
    t.ma = ma; t.md = md;
    return t;
  endfunction

  task automatic idle_in();
    req0_valid = 0; req0_write = 0;
    req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_write = 0;
    req1_addr = 0; req1_wdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    idle_in();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    logic [6:0] fl;
    if (t.rst) do_reset();
    else @(negedge clock);
    req0_valid = t.v0; req0_write = t.w0;
    req0_addr = t.a0; req0_wdata = t.d0;
    req1_valid = t.v1; req1_write = t.w1;
    req1_addr = t.a1; req1_wdata = t.d1;
    #1;
    fl = {req0_ready, req1_ready, mem_we,
          req0_rvalid, req1_rvalid,
          req0_err, req1_err};
    vectors++;
    if (fl !== t.fl || req0_rdata !== t.rd0 ||
        req1_rdata !== t.rd1 || mem_addr !== t.ma ||
        mem_wdata !== t.md) begin
      miscompares++;
      $display("FAIL %s: got fl=%b rd0=%h rd1=%h ma=%h md=%h want fl=%b rd0=%h rd1=%h ma=%h md=%h",
        t.nm, fl, req0_rdata, req1_rdata, mem_addr,
        mem_wdata, t.fl, t.rd0, t.rd1, t.ma, t.md);
    end
  endtask

  localparam logic [31:0] BEEF = 32'hDEADBEEF;
  localparam logic [31:0] TOPV = 32'h12345678;
  localparam logic [31:0] D1   = 32'h11111111;
  localparam logic [31:0] D2   = 32'h22222222;

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    idle_in();
    for (int i = 0; i < 1024; i++)
      mem[i] = 32'hA000_0000 | 32'(i << 2);

    vq.push_back(mk("rst", 1, 0,0,0,0, 0,0,0,0, 7'b0000000, 0,0, 0,0));
    vq.push_back(mk("w0_acc", 0, 1,1,32'h10,BEEF, 0,0,0,0, 7'b1000000, 0,0, 0,0));
    vq.push_back(mk("w0_mem", 0, 0,0,0,0, 0,0,0,0, 7'b0010000, 0,0, 32'h10,BEEF));
    vq.push_back(mk("w0_rsp", 0, 0,0,0,0, 0,0,0,0, 7'b0001000, 0,0, 32'h10,BEEF));
    vq.push_back(mk("r0_acc", 0, 1,0,32'h10,0, 0,0,0,0, 7'b1000000, 0,0, 32'h10,BEEF));
    vq.push_back(mk("r0_mem", 0, 0,0,0,0, 0,0,0,0, 7'b0000000, 0,0, 32'h10,0));
    vq.push_back(mk("r0_rsp", 0, 0,0,0,0, 0,0,0,0, 7'b0001000, BEEF,0, 32'h10,0));

    vq.push_back(mk("c1_g0", 1, 1,0,32'h100,0, 1,0,32'h200,0, 7'b1000000, 0,0, 0,0));
    vq.push_back(mk("c2_acc", 0, 1,0,32'h100,0, 1,0,32'h200,0, 7'b0000000, 0,0, 32'h100,0));
    vq.push_back(mk("c3_rv0", 0, 1,0,32'h100,0, 1,0,32'h200,0, 7'b0001000, 32'hA0000100,0, 32'h100,0));
    vq.push_back(mk("c4_g1", 0, 1,0,32'h100,0, 1,0,32'h200,0, 7'b0100000, 0,0, 32'h100,0));
    vq.push_back(mk("c5_acc", 0, 1,0,32'h100,0, 1,0,32'h200,0, 7'b0000000, 0,0, 32'h200,0));
    vq.push_back(mk("c6_rv1", 0, 1,0,32'h100,0, 1,0,32'h200,0, 7'b0000100, 0,32'hA0000200, 32'h200,0));
    vq.push_back(mk("c7_g0", 0, 1,0,32'h100,0, 1,0,32'h200,0, 7'b1000000, 0,0, 32'h200,0));
    vq.push_back(mk("c8_acc", 0, 1,0,32'h100,0, 1,0,32'h200,0, 7'b0000000, 0,0, 32'h100,0));
    vq.push_back(mk("c9_rv0", 0, 1,0,32'h100,0, 1,0,32'h200,0, 7'b0001000, 32'hA0000100,0, 32'h100,0));
    vq.push_back(mk("c10_g1", 0, 1,0,32'h100,0, 1,0,32'h200,0, 7'b0100000, 0,0, 32'h100,0));
    vq.push_back(mk("c11_acc", 0, 0,0,0,0, 0,0,0,0, 7'b0000000, 0,0, 32'h200,0));
    vq.push_back(mk("c12_rv1", 0, 0,0,0,0, 0,0,0,0, 7'b0000100, 0,32'hA0000200, 32'h200,0));

    vq.push_back(mk("e1_acc", 0, 0,0,0,0, 1,1,32'h1002,D1, 7'b0100000, 0,0, 32'h200,0));
    vq.push_back(mk("e2_nowe", 0, 0,0,0,0, 0,0,0,0, 7'b0000000, 0,0, 32'h1002,D1));
    vq.push_back(mk("e3_err", 0, 0,0,0,0, 0,0,0,0, 7'b0000101, 0,0, 32'h1002,D1));
    vq.push_back(mk("e4_acc", 0, 0,0,0,0, 1,1,32'h1000,D2, 7'b0100000, 0,0, 32'h1002,D1));
    vq.push_back(mk("e5_nowe", 0, 0,0,0,0, 0,0,0,0, 7'b0000000, 0,0, 32'h1000,D2));
    vq.push_back(mk("e6_err", 0, 0,0,0,0, 0,0,0,0, 7'b0000101, 0,0, 32'h1000,D2));
    vq.push_back(mk("e7_acc", 0, 0,0,0,0, 1,0,32'h0,0, 7'b0100000, 0,0, 32'h1000,D2));
    vq.push_back(mk("e8_mem", 0, 0,0,0,0, 0,0,0,0, 7'b0000000, 0,0, 0,0));
    vq.push_back(mk("e9_keep", 0, 0,0,0,0, 0,0,0,0, 7'b0000100, 0,32'hA0000000, 0,0));

    vq.push_back(mk("t1_acc", 0, 1,1,32'hFFC,TOPV, 0,0,0,0, 7'b1000000, 0,0, 0,0));
    vq.push_back(mk("t2_mem", 0, 0,0,0,0, 0,0,0,0, 7'b0010000, 0,0, 32'hFFC,TOPV));
    vq.push_back(mk("t3_rsp", 0, 0,0,0,0, 0,0,0,0, 7'b0001000, 0,0, 32'hFFC,TOPV));
    vq.push_back(mk("t4_acc", 0, 1,0,32'hFFC,0, 0,0,0,0, 7'b1000000, 0,0, 32'hFFC,TOPV));
    vq.push_back(mk("t5_mem", 0, 0,0,0,0, 0,0,0,0, 7'b0000000, 0,0, 32'hFFC,0));
    vq.push_back(mk("t6_rsp", 0, 0,0,0,0, 0,0,0,0, 7'b0001000, TOPV,0, 32'hFFC,0));

    foreach (vq[i]) apply(vq[i]);

    // Reset lands in the middle of a write's ACCESS cycle.
    @(negedge clock);
    req0_valid = 1; req0_write = 1;
    req0_addr = 32'h20; req0_wdata = 32'h5555AAAA;
    #1 chk("rs_ready0", {31'b0, req0_ready}, 1);
    @(negedge clock);
    idle_in();
    #1 chk("rs_we_hi", {31'b0, mem_we}, 1);
    chk("rs_maddr", mem_addr, 32'h20);
    #1 reset_n = 1'b0;
    #1 chk("rs_we_drop", {31'b0, mem_we}, 0);
    @(negedge clock);
    #1 chk("rs_rv_in_rst", {30'b0, req1_rvalid, req0_rvalid}, 0);
    reset_n = 1'b1;
    @(negedge clock);
    #1 chk("rs_rv_after1", {30'b0, req1_rvalid, req0_rvalid}, 0);
    chk("rs_mem_kept", mem[8], 32'hA0000020);

    req0_valid = 1; req0_addr = 32'h100;
    req1_valid = 1; req1_addr = 32'h200;
    #1 chk("rs_contend", {30'b0, req1_ready, req0_ready}, 2'b01);
    @(negedge clock);
    idle_in();
    @(negedge clock);
    #1 chk("rs_c_rv0", {30'b0, req1_rvalid, req0_rvalid}, 2'b01);

    @(negedge clock);
    req0_valid = 1; req0_addr = 32'h20;
    #1 chk("rs_rd_ready", {31'b0, req0_ready}, 1);
    @(negedge clock);
    idle_in();
    @(negedge clock);
    #1 chk("rs_rd_rv", {31'b0, req0_rvalid}, 1);
    chk("rs_rd_data", req0_rdata, 32'hA0000020);
    chk("rs_rd_err", {31'b0, req0_err}, 0);

    @(negedge clock);
    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
